// File: rtl/packet_merger_pkg.sv
// Shared types and constants for the two-input packet merger.
// The arbitration helper picks the next grant from IDLE using the round-robin pointer.
package packet_merger_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } grant_state_t;

  localparam int SKID_DEPTH = 2;

  // ptr = 0 favours S0 when both inputs are waiting, ptr = 1 favours S1.
  function automatic grant_state_t arbitrate(input logic v0, input logic v1, input logic ptr);
    grant_state_t g;
    g = IDLE;
    if (v0 && (!v1 || !ptr)) begin
      g = GRANT0;
    end else if (v1) begin
      g = GRANT1;
    end
    return g;
  endfunction

endpackage

// File: rtl/packet_merger_skid.sv
// Two-entry registered skid buffer: the output comes straight from a register and
// s_ready depends only on the buffer occupancy register, never on m_ready.
module packet_merger_skid
  import packet_merger_pkg::*;
#(
  parameter int TDATA_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [TDATA_WIDTH-1:0] s_data,
  input  logic                   s_last,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [TDATA_WIDTH-1:0] m_data,
  output logic                   m_last
);

  localparam int OCC_W = $clog2(SKID_DEPTH + 1);
  localparam logic [OCC_W-1:0] OCC_EMPTY = OCC_W'(0);
  localparam logic [OCC_W-1:0] OCC_ONE   = OCC_W'(1);
  localparam logic [OCC_W-1:0] OCC_FULL  = OCC_W'(SKID_DEPTH);

  logic [OCC_W-1:0]       occ_q, occ_d;
  logic [TDATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                   out_last_q, out_last_d;
  logic [TDATA_WIDTH-1:0] sk_data_q, sk_data_d;
  logic                   sk_last_q, sk_last_d;
  logic                   push, pop;

  assign s_ready = (occ_q < OCC_FULL);
  assign m_valid = (occ_q != OCC_EMPTY);
  assign m_data  = out_data_q;
  assign m_last  = out_last_q;

  assign push = s_valid && s_ready;
  assign pop  = m_valid && m_ready;

  always_comb begin
    occ_d      = occ_q + OCC_W'(push) - OCC_W'(pop);
    out_data_d = out_data_q;
    out_last_d = out_last_q;
    sk_data_d  = sk_data_q;
    sk_last_d  = sk_last_q;
    // When full, push is impossible, so a pop simply promotes the parked beat.
    if (pop && (occ_q == OCC_FULL)) begin
      out_data_d = sk_data_q;
      out_last_d = sk_last_q;
    end
    if (push && ((occ_q == OCC_EMPTY) || ((occ_q == OCC_ONE) && pop))) begin
      out_data_d = s_data;
      out_last_d = s_last;
    end
    if (push && (occ_q == OCC_ONE) && !pop) begin
      sk_data_d = s_data;
      sk_last_d = s_last;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      occ_q      <= OCC_EMPTY;
      out_data_q <= '0;
      out_last_q <= 1'b0;
      sk_data_q  <= '0;
      sk_last_q  <= 1'b0;
    end else begin
      occ_q      <= occ_d;
      out_data_q <= out_data_d;
      out_last_q <= out_last_d;
      sk_data_q  <= sk_data_d;
      sk_last_q  <= sk_last_d;
    end
  end

endmodule

// File: rtl/packet_merger.sv
// Packet-atomic round-robin merge of two AXI-Stream inputs into one registered output,
// with per-input packet counters.
module packet_merger
  import packet_merger_pkg::*;
#(
  parameter int TDATA_WIDTH = 32,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [TDATA_WIDTH-1:0] s0_axis_tdata,
  input  logic                   s0_axis_tlast,
  input  logic                   s0_axis_tvalid,
  output logic                   s0_axis_tready,
  input  logic [TDATA_WIDTH-1:0] s1_axis_tdata,
  input  logic                   s1_axis_tlast,
  input  logic                   s1_axis_tvalid,
  output logic                   s1_axis_tready,
  output logic [TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                   m_axis_tlast,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [CNT_WIDTH-1:0]   num_packets_from_input_0,
  output logic [CNT_WIDTH-1:0]   num_packets_from_input_1
);

  // Handshakes are plain AXI-Stream: a beat moves on a rising clk edge where
  // valid && ready; valid never waits on ready and holds its payload until taken.

  grant_state_t           state_q, state_d;
  logic                   ptr_q, ptr_d;
  logic [CNT_WIDTH-1:0]   pkt_cnt0_q, pkt_cnt0_d;
  logic [CNT_WIDTH-1:0]   pkt_cnt1_q, pkt_cnt1_d;

  logic                   skid_in_valid;
  logic                   skid_in_ready;
  logic [TDATA_WIDTH-1:0] skid_in_data;
  logic                   skid_in_last;
  logic                   s0_hs, s1_hs;
  logic                   s0_eop, s1_eop;

  assign s0_hs  = s0_axis_tvalid && s0_axis_tready;
  assign s1_hs  = s1_axis_tvalid && s1_axis_tready;
  assign s0_eop = s0_hs && s0_axis_tlast;
  assign s1_eop = s1_hs && s1_axis_tlast;

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; the grant is released only on the granted input's tlast.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = arbitrate(s0_axis_tvalid, s1_axis_tvalid, ptr_q);
      GRANT0:  if (s0_eop) state_d = IDLE;
      GRANT1:  if (s1_eop) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: only the granted input sees ready, and only while the buffer has room.
  always_comb begin
    s0_axis_tready = (state_q == GRANT0) && skid_in_ready;
    s1_axis_tready = (state_q == GRANT1) && skid_in_ready;
    skid_in_valid  = s0_hs || s1_hs;
    skid_in_data   = s0_axis_tdata;
    skid_in_last   = s0_axis_tlast;
    if (state_q == GRANT1) begin
      skid_in_data = s1_axis_tdata;
      skid_in_last = s1_axis_tlast;
    end
  end

  // Pointer hands priority to the other input once a packet completes.
  always_comb begin
    ptr_d      = ptr_q;
    pkt_cnt0_d = pkt_cnt0_q;
    pkt_cnt1_d = pkt_cnt1_q;
    if (s0_eop) begin
      ptr_d      = 1'b1;
      pkt_cnt0_d = pkt_cnt0_q + CNT_WIDTH'(1);
    end
    if (s1_eop) begin
      ptr_d      = 1'b0;
      pkt_cnt1_d = pkt_cnt1_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr_q      <= 1'b0;
      pkt_cnt0_q <= '0;
      pkt_cnt1_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      pkt_cnt0_q <= pkt_cnt0_d;
      pkt_cnt1_q <= pkt_cnt1_d;
    end
  end

  assign num_packets_from_input_0 = pkt_cnt0_q;
  assign num_packets_from_input_1 = pkt_cnt1_q;

  packet_merger_skid #(
    .TDATA_WIDTH(TDATA_WIDTH)
  ) u_skid (
    .clk     (clk),
    .resetn  (resetn),
    .s_valid (skid_in_valid),
    .s_ready (skid_in_ready),
    .s_data  (skid_in_data),
    .s_last  (skid_in_last),
    .m_valid (m_axis_tvalid),
    .m_ready (m_axis_tready),
    .m_data  (m_axis_tdata),
    .m_last  (m_axis_tlast)
  );

endmodule

// File: tb/tb_packet_merger.sv
// Directed bench for packet_merger: drivers issue packets, expected beats are queued
// up front in the order round-robin arbitration must produce, and a monitor checks M.
module tb_packet_merger;

  localparam int DW = 32;
  localparam int CW = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] s0_axis_tdata = '0, s1_axis_tdata = '0;
  logic          s0_axis_tlast = 1'b0, s1_axis_tlast = 1'b0;
  logic          s0_axis_tvalid = 1'b0, s1_axis_tvalid = 1'b0;
  logic          s0_axis_tready, s1_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tlast, m_axis_tvalid;
  logic          m_axis_tready = 1'b0;
  logic [CW-1:0] num_packets_from_input_0, num_packets_from_input_1;

  packet_merger #(.TDATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk                      (clk),
    .resetn                   (resetn),
    .s0_axis_tdata            (s0_axis_tdata),
    .s0_axis_tlast            (s0_axis_tlast),
    .s0_axis_tvalid           (s0_axis_tvalid),
    .s0_axis_tready           (s0_axis_tready),
    .s1_axis_tdata            (s1_axis_tdata),
    .s1_axis_tlast            (s1_axis_tlast),
    .s1_axis_tvalid           (s1_axis_tvalid),
    .s1_axis_tready           (s1_axis_tready),
    .m_axis_tdata             (m_axis_tdata),
    .m_axis_tlast             (m_axis_tlast),
    .m_axis_tvalid            (m_axis_tvalid),
    .m_axis_tready            (m_axis_tready),
    .num_packets_from_input_0 (num_packets_from_input_0),
    .num_packets_from_input_1 (num_packets_from_input_1)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [DW:0] exp_q[$];
  int hs_cyc[$];

  always @(posedge clk) cyc++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    step();
    step();
    resetn = 1'b1;
    step();
  endtask

  // ---------------- scoreboard monitor ----------------
  // Sampled at negedge: the values seen here are what the next rising edge acts on.
  logic          stall_prev = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;

  always @(negedge clk) begin
    if (!resetn) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        total++;
        if (!m_axis_tvalid || m_axis_tdata !== prev_data || m_axis_tlast !== prev_last) begin
          bad++;
          $display("FAIL stall_hold: got v=%0b d=%0h l=%0b want v=1 d=%0h l=%0b",
                   m_axis_tvalid, m_axis_tdata, m_axis_tlast, prev_data, prev_last);
        end
      end
      stall_prev = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
      prev_last  = m_axis_tlast;
      if (m_axis_tvalid && m_axis_tready) begin
        logic [DW:0] e;
        total++;
        hs_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL m_beat: got unexpected %0h last=%0b want none", m_axis_tdata, m_axis_tlast);
        end else begin
          e = exp_q.pop_front();
          if ({m_axis_tlast, m_axis_tdata} !== e) begin
            bad++;
            $display("FAIL m_beat: got %0h last=%0b want %0h last=%0b",
                     m_axis_tdata, m_axis_tlast, e[DW-1:0], e[DW]);
          end
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic drive_beat(input int src, input logic [DW-1:0] data, input logic last);
    int n;
    logic ok;
    if (src == 0) begin
      s0_axis_tvalid = 1'b1; s0_axis_tdata = data; s0_axis_tlast = last;
    end else begin
      s1_axis_tvalid = 1'b1; s1_axis_tdata = data; s1_axis_tlast = last;
    end
    n = 0;
    ok = 1'b0;
    while (!ok && n < 200) begin
      @(negedge clk);
      if ((src == 0) ? s0_axis_tready : s1_axis_tready) ok = 1'b1;
      else n++;
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL s%0d_timeout: got no tready want tready within 200 cycles", src);
    end
    @(posedge clk);
    #1;
    if (src == 0) s0_axis_tvalid = 1'b0;
    else s1_axis_tvalid = 1'b0;
  endtask

  task automatic send_pkt(input int src, input logic [DW-1:0] base, input int len);
    for (int i = 0; i < len; i++) drive_beat(src, base + DW'(i), (i == len - 1));
  endtask

  task automatic expect_pkt(input logic [DW-1:0] base, input int len);
    for (int i = 0; i < len; i++) exp_q.push_back({(i == len - 1), base + DW'(i)});
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(exp_q.size()), 64'd0);
    step();
  endtask

  task automatic check_gaps(input string name, input int gap);
    for (int i = 1; i < hs_cyc.size(); i++) check(name, 64'(hs_cyc[i] - hs_cyc[i-1]), 64'(gap));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end want end before 200000");
    $fatal(1);
  end

  // ---------------- directed tests ----------------
  initial begin
    logic idle_ok;
    logic pat [4];
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;

    // Reset release, no traffic.
    step();
    do_reset();
    m_axis_tready = 1'b1;
    @(negedge clk);
    check("reset_m", {m_axis_tvalid, m_axis_tlast, m_axis_tdata}, 64'd0);
    check("reset_ready", {s0_axis_tready, s1_axis_tready}, 64'd0);
    check("reset_cnt", {num_packets_from_input_0, num_packets_from_input_1}, 64'd0);
    idle_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m_axis_tvalid) idle_ok = 1'b0;
    end
    check("idle_20", 64'(idle_ok), 64'd1);
    step();

    // Single 4-beat S0 packet: latency 2, full rate.
    hs_cyc.delete();
    expect_pkt(32'hA0, 4);
    fork
      send_pkt(0, 32'hA0, 4);
      begin
        @(posedge clk); @(negedge clk);
        check("lat_c1_valid", 64'(m_axis_tvalid), 64'd0);
        @(posedge clk); @(negedge clk);
        check("lat_c2_beat", {m_axis_tvalid, m_axis_tdata}, {32'd1, 32'hA0});
      end
    join
    wait_drain("drain_a");
    check_gaps("a_rate", 1);
    check("a_cnt0", 64'(num_packets_from_input_0), 64'd1);
    check("a_cnt1", 64'(num_packets_from_input_1), 64'd0);

    // Both inputs busy from reset: strict packet alternation starting with S0.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      expect_pkt(32'h100 + 32'(3*k), 3);
      expect_pkt(32'h200 + 32'(3*k), 3);
    end
    fork
      for (int k = 0; k < 3; k++) send_pkt(0, 32'h100 + 32'(3*k), 3);
      for (int k = 0; k < 3; k++) send_pkt(1, 32'h200 + 32'(3*k), 3);
    join
    wait_drain("drain_rr");
    check("rr_cnt0", 64'(num_packets_from_input_0), 64'd3);
    check("rr_cnt1", 64'(num_packets_from_input_1), 64'd3);

    // 8-beat S1 packet under a 1,0,0,1 backpressure pattern.
    expect_pkt(32'h300, 8);
    fork
      send_pkt(1, 32'h300, 8);
      for (int k = 0; k < 200 && exp_q.size() != 0; k++) begin
        m_axis_tready = pat[k % 4];
        step();
      end
    join
    m_axis_tready = 1'b1;
    wait_drain("drain_bp");
    check("bp_cnt1", 64'(num_packets_from_input_1), 64'd4);

    // Alternating single-beat packets: one idle cycle between packets on M.
    do_reset();
    hs_cyc.delete();
    for (int k = 0; k < 3; k++) begin
      expect_pkt(32'hC0 + 32'(k), 1);
      expect_pkt(32'hD0 + 32'(k), 1);
    end
    fork
      for (int k = 0; k < 3; k++) send_pkt(0, 32'hC0 + 32'(k), 1);
      for (int k = 0; k < 3; k++) send_pkt(1, 32'hD0 + 32'(k), 1);
    join
    wait_drain("drain_single");
    check_gaps("single_gap", 2);
    check("single_cnt0", 64'(num_packets_from_input_0), 64'd3);
    check("single_cnt1", 64'(num_packets_from_input_1), 64'd3);

    // Counter wrap on S1.
    force dut.pkt_cnt1_q = 32'hFFFF_FFFF;
    step();
    step();
    release dut.pkt_cnt1_q;
    step();
    check("wrap_preset", 64'(num_packets_from_input_1), 64'hFFFF_FFFF);
    expect_pkt(32'hE0, 1);
    send_pkt(1, 32'hE0, 1);
    wait_drain("drain_wrap");
    check("wrap_cnt1", 64'(num_packets_from_input_1), 64'd0);
    check("wrap_cnt0", 64'(num_packets_from_input_0), 64'd3);

    // Reset mid-packet with the buffer full, then a fresh packet.
    m_axis_tready = 1'b0;
    s0_axis_tvalid = 1'b1; s0_axis_tdata = 32'hF0; s0_axis_tlast = 1'b0;
    step();
    step();
    s0_axis_tdata = 32'hF1;
    step();
    s0_axis_tdata = 32'hF2;
    step();
    @(negedge clk);
    check("mid_full", {m_axis_tvalid, s0_axis_tready, m_axis_tdata}, {1'b1, 1'b0, 32'hF0});
    #2;
    resetn = 1'b0;
    #1;
    check("mid_rst_m", {m_axis_tvalid, m_axis_tlast, m_axis_tdata}, 64'd0);
    check("mid_rst_cnt", {num_packets_from_input_0, num_packets_from_input_1}, 64'd0);
    check("mid_rst_ready", {s0_axis_tready, s1_axis_tready}, 64'd0);
    @(negedge clk);
    s0_axis_tvalid = 1'b0;
    step();
    resetn = 1'b1;
    m_axis_tready = 1'b1;
    step();
    expect_pkt(32'hF3, 1);
    send_pkt(0, 32'hF3, 1);
    wait_drain("drain_post_rst");
    check("post_rst_cnt0", 64'(num_packets_from_input_0), 64'd1);
    check("post_rst_cnt1", 64'(num_packets_from_input_1), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
